shift_sub_divider: RTL
======================

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have clk  input  1  clock.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have flush  input  1  pipeline flush on branch mispredict; same effect as rst.
REQ-005 SHALL have start  input  1  request; held high until done seen, then dropped.
REQ-006 SHALL have div_type  input  2  operation: 0 unsigned/unsigned, 1 signed/signed, others reserved (treated as unsigned).
REQ-007 SHALL have a  input  OPERAND_WIDTH  dividend.
REQ-008 SHALL have b  input  OPERAND_WIDTH  divisor.
REQ-009 SHALL have quotient  output  OPERAND_WIDTH  result quotient, valid while done.
REQ-010 SHALL have remainder  output  OPERAND_WIDTH  result remainder, valid while done.
REQ-011 SHALL have done  output  1  result valid.

Function
REQ-012 SHALL implement states IDLE, CALC, FIXUP, DONE.
REQ-013 SHALL sample a, b, div_type only in IDLE on a clock edge with start=1; other inputs ignored until return to IDLE.
REQ-014 SHALL, for normal operands, go IDLE->CALC, spend exactly OPERAND_WIDTH cycles in CALC (one restoring shift-subtract step per cycle, iteration counter), then one cycle in FIXUP, then DONE; done first high OPERAND_WIDTH+2 cycles after the sampling edge.
REQ-015 SHALL, in signed mode, divide magnitudes; quotient negated iff operand signs differ; remainder takes dividend sign; negation applied in FIXUP.
REQ-016 SHALL, when b=0, go IDLE->DONE with quotient all-ones and remainder=a, done one cycle after sampling edge.
REQ-017 SHALL, when signed and a=most-negative and b=all-ones (-1), go IDLE->DONE with quotient=a, remainder=0, done one cycle after sampling edge.
REQ-018 SHALL remain in DONE with done=1 and stable results while start=1; go to IDLE the cycle after start=0.
REQ-019 SHALL drive done, quotient, remainder to 0 in every state except DONE.
REQ-020 SHALL compute remainder with an OPERAND_WIDTH+1-bit partial remainder so no unsigned carry is lost.
REQ-021 SHALL give flush priority over all state updates; flush mid-CALC discards the operation, next state IDLE, counter cleared.

Reset
REQ-022 SHALL on rst or flush set state IDLE, clear counter, partial remainder, quotient register, stored divisor and sign flags; outputs 0 the following cycle.
REQ-023 SHALL accept a new start the first cycle after rst/flush deasserts.

Configuration
REQ-024 SHALL support macro DIVIDER_EARLY_OUT_EN: when defined, if |a| < |b| (magnitudes, b nonzero) go IDLE->DONE with quotient 0, remainder=a, done one cycle after sampling edge; when undefined such operands take the full REQ-014 latency with identical results.

Structure
REQ-025 SHALL take div_type encodings as a typedef enum from shared package mul_div_pkg, which also holds the multiplier type encodings; state enum stays local.
REQ-026 SHALL be a single module; no sub-module needed.

Verification
REQ-027 SHALL cover unsigned: a=100, b=7 -> quotient 14, remainder 2, done at cycle 34 after start (OPERAND_WIDTH=32).
REQ-028 SHALL cover signed: a=-7 (0xFFFFFFF9), b=2 -> quotient -3 (0xFFFFFFFD), remainder -1 (0xFFFFFFFF).
REQ-029 SHALL cover divide-by-zero: a=0x1234, b=0, signed and unsigned -> quotient 0xFFFFFFFF, remainder 0x1234, done one cycle after start.
REQ-030 SHALL cover overflow: signed a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000, remainder 0; same operands unsigned -> quotient 0, remainder 0x80000000.
REQ-031 SHALL cover flush at CALC cycle 10 -> done never asserts, IDLE next cycle; a following start with a=9, b=3 -> quotient 3, remainder 0.
REQ-032 SHALL cover handshake: start held 5 cycles past done -> done and results stable throughout; done=0 one cycle after start drops; with DIVIDER_EARLY_OUT_EN, a=3, b=10 -> quotient 0, remainder 3 in 1 cycle.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared encodings for the multiply/divide unit: divider operation select and multiplier operation select.
package mul_div_pkg;

   typedef enum logic [1:0] {
      DIV_UNSIGNED = 2'd0,
      DIV_SIGNED   = 2'd1,
      DIV_RSVD_2   = 2'd2,
      DIV_RSVD_3   = 2'd3
   } div_type_e;

   typedef enum logic [1:0] {
      MUL_LO    = 2'd0,
      MUL_HI_SS = 2'd1,
      MUL_HI_UU = 2'd2,
      MUL_HI_SU = 2'd3
   } mul_type_e;

endpackage

// File: rtl/shift_sub_divider.sv
// Iterative restoring shift-subtract divider, one quotient bit per cycle, signed or unsigned.
// Optional DIVIDER_EARLY_OUT_EN: finishes immediately when |a| < |b|.
module shift_sub_divider
   import mul_div_pkg::*;
#(
   parameter int unsigned OPERAND_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     start,
   input  div_type_e                div_type,
   input  logic [OPERAND_WIDTH-1:0] a,
   input  logic [OPERAND_WIDTH-1:0] b,
   output logic [OPERAND_WIDTH-1:0] quotient,
   output logic [OPERAND_WIDTH-1:0] remainder,
   output logic                     done
);

   localparam int unsigned W     = OPERAND_WIDTH;
   localparam int unsigned CNT_W = $clog2(W + 1);
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

   state_e         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W:0]     rem_q, rem_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [W-1:0]   div_q, div_d;
   logic           neg_quo_q, neg_quo_d;
   logic           neg_rem_q, neg_rem_d;
   logic [W-1:0]   quotient_d, remainder_d;
   logic           done_d;

   logic           is_signed, a_neg, b_neg, b_zero, ovf;
   logic [W-1:0]   abs_a, abs_b;
   logic [W+1:0]   shifted, diff;
   logic           step_ge;

   // Operand classification, only meaningful in IDLE
   assign is_signed = (div_type == DIV_SIGNED);
   assign a_neg     = is_signed & a[W-1];
   assign b_neg     = is_signed & b[W-1];
   assign abs_a     = a_neg ? (~a + W'(1)) : a;
   assign abs_b     = b_neg ? (~b + W'(1)) : b;
   assign b_zero    = (b == '0);
   assign ovf       = is_signed && (a == MOST_NEG) && (&b);

   // Restoring step: shift next dividend bit into the partial remainder and trial-subtract
   assign shifted = {rem_q, quo_q[W-1]};
   assign diff    = shifted - (W+2)'(div_q);
   assign step_ge = (shifted >= (W+2)'(div_q));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      div_d       = div_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      done_d      = 1'b0;
      quotient_d  = '0;
      remainder_d = '0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (b_zero) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  quotient_d  = '1;
                  remainder_d = a;
               end else if (ovf) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  quotient_d  = a;
`ifdef DIVIDER_EARLY_OUT_EN
               end else if (abs_a < abs_b) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  remainder_d = a;
`endif
               end else begin
                  state_d   = CALC;
                  cnt_d     = '0;
                  rem_d     = '0;
                  quo_d     = abs_a;
                  div_d     = abs_b;
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
               end
            end
         end
         CALC: begin
            rem_d = step_ge ? (W+1)'(diff) : (W+1)'(shifted);
            quo_d = {quo_q[W-2:0], step_ge};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) begin
               state_d = FIXUP;
            end
         end
         FIXUP: begin
            state_d     = DONE;
            done_d      = 1'b1;
            quotient_d  = neg_quo_q ? (~quo_q + W'(1)) : quo_q;
            remainder_d = neg_rem_q ? (~rem_q[W-1:0] + W'(1)) : rem_q[W-1:0];
         end
         DONE: begin
            if (start) begin
               done_d      = 1'b1;
               quotient_d  = quotient;
               remainder_d = remainder;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Flush behaves exactly like reset and overrides every update
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         div_q     <= div_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         done      <= done_d;
         quotient  <= quotient_d;
         remainder <= remainder_d;
      end
   end

endmodule
